// File: rtl/dmem_lsu_if.sv
// Load/store request, response and data-memory port bundle for dmem_lsu.
// The master side is the pipeline plus the memory; the slave side is the LSU.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [3:0]  mem_amp;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_amp, mem_a, mem_wd
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_amp, mem_a, mem_wd
  );
endinterface

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: IDLE -> ACCESS (1 beat, or 2/4 byte beats) -> RESP pulse.
// Optional MISALIGN_EN splits misaligned half/word accesses into byte beats; otherwise they error.
module dmem_lsu (
  input  logic        clk,
  input  logic        rstn,
  dmem_lsu_if.slave   bus
);

`ifdef MISALIGN_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;

  logic [1:0]  state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic        split_q;
  logic [1:0]  beat_q;
  logic [31:0] buf_q;

  logic        accept;
  logic        misal;
  logic        illegal;
  logic [1:0]  last_beat;
  logic [31:0] addr_k;
  logic [31:0] cap;
  logic [31:0] ext;

  assign bus.req_ready = rstn && (state == S_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  assign misal   = ((bus.req_size == SZ_H) && bus.req_addr[0]) ||
                   ((bus.req_size == SZ_W) && (bus.req_addr[1:0] != 2'b00));
  assign illegal = (bus.req_size == SZ_X) || (misal && !MIS_EN);

  assign last_beat = !split_q ? 2'd0 : ((size_q == SZ_W) ? 2'd3 : 2'd1);
  // Beat address wraps naturally at 2^32; for unsplit accesses beat_q is 0.
  assign addr_k    = addr_q + {30'd0, beat_q};

  always_comb begin
    bus.mem_we  = 1'b0;
    bus.mem_amp = 4'b0000;
    bus.mem_a   = 32'd0;
    bus.mem_wd  = 32'd0;
    if (state == S_ACCESS) begin
      bus.mem_we = we_q;
      bus.mem_a  = {addr_k[31:2], 2'b00};
      if (split_q) begin
        bus.mem_amp = 4'b0001 << addr_k[1:0];
        bus.mem_wd  = {4{wdata_q[8*beat_q +: 8]}};
      end else begin
        case (size_q)
          SZ_B: begin
            bus.mem_amp = 4'b0001 << addr_q[1:0];
            bus.mem_wd  = {4{wdata_q[7:0]}};
          end
          SZ_H: begin
            bus.mem_amp = 4'b0011 << addr_q[1:0];
            bus.mem_wd  = {2{wdata_q[15:0]}};
          end
          default: begin
            bus.mem_amp = 4'b1111;
            bus.mem_wd  = wdata_q;
          end
        endcase
      end
    end
  end

  // Load capture: raw lane right-justified; split beats assemble byte k into bits [8k+:8].
  always_comb begin
    cap = buf_q;
    if (split_q) begin
      cap[8*beat_q +: 8] = bus.mem_rd[8*addr_k[1:0] +: 8];
    end else begin
      case (size_q)
        SZ_B:    cap = {24'd0, bus.mem_rd[8*addr_q[1:0] +: 8]};
        SZ_H:    cap = {16'd0, bus.mem_rd[16*addr_q[1] +: 16]};
        default: cap = bus.mem_rd;
      endcase
    end
  end

  always_comb begin
    case (size_q)
      SZ_B:    ext = {{24{buf_q[7]  && !uns_q}}, buf_q[7:0]};
      SZ_H:    ext = {{16{buf_q[15] && !uns_q}}, buf_q[15:0]};
      default: ext = buf_q;
    endcase
  end

  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_err   = (state == S_RESP) && err_q;
  assign bus.rsp_rdata = ((state == S_RESP) && !err_q && !we_q) ? ext : 32'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      beat_q  <= 2'd0;
      buf_q   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            err_q   <= illegal;
            split_q <= misal && !illegal;
            beat_q  <= 2'd0;
            buf_q   <= 32'd0;
            state   <= illegal ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!we_q) begin
            buf_q <= cap;
          end
          if (beat_q == last_beat) begin
            state <= S_RESP;
          end else begin
            beat_q <= beat_q + 2'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: stores, signed/unsigned loads, illegal size,
// misaligned access (either build) and reset asserted during ACCESS.
module tb_dmem_lsu;
  logic clk;
  logic rstn;
  logic [31:0] rd_lo;
  logic [31:0] rd_hi;
  int n_pass;
  int n_total;

  dmem_lsu_if bus ();

  dmem_lsu u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Two-word memory image: bit 2 of the address selects the word.
  assign bus.mem_rd = bus.mem_a[2] ? rd_hi : rd_lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, waits (bounded) for req_ready, returns in the first post-acceptance cycle.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    for (int i = 0; i < 8 && !bus.req_ready; i++) tick();
    check("accept_wait", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rstn    = 1'b0;
    rd_lo   = 32'h8012_3456;
    rd_hi   = 32'h0000_0044;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;

    #12;
    check("rst_ready",  32'(bus.req_ready), 32'd0);
    check("rst_rvalid", 32'(bus.rsp_valid), 32'd0);
    check("rst_we",     32'(bus.mem_we),    32'd0);
    check("rst_amp",    32'(bus.mem_amp),   32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("idle_ready", 32'(bus.req_ready), 32'd1);
    check("idle_a",     bus.mem_a,          32'd0);

    // Store word 0x100
    issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF);
    check("sw_we",     32'(bus.mem_we),    32'd1);
    check("sw_a",      bus.mem_a,          32'h100);
    check("sw_amp",    32'(bus.mem_amp),   32'hF);
    check("sw_wd",     bus.mem_wd,         32'hDEAD_BEEF);
    check("sw_ready",  32'(bus.req_ready), 32'd0);
    check("sw_early",  32'(bus.rsp_valid), 32'd0);
    tick();
    check("sw_rvalid", 32'(bus.rsp_valid), 32'd1);
    check("sw_err",    32'(bus.rsp_err),   32'd0);
    check("sw_rdata",  bus.rsp_rdata,      32'd0);
    check("sw_we_off", 32'(bus.mem_we),    32'd0);
    tick();
    check("sw_pulse",  32'(bus.rsp_valid), 32'd0);
    check("sw_idle",   32'(bus.req_ready), 32'd1);

    // Load byte 0x103 signed then unsigned
    issue(1'b0, 2'd0, 1'b0, 32'h103, 32'd0);
    check("lb_we",    32'(bus.mem_we),  32'd0);
    check("lb_amp",   32'(bus.mem_amp), 32'h8);
    check("lb_a",     bus.mem_a,        32'h100);
    tick();
    check("lb_rvalid", 32'(bus.rsp_valid), 32'd1);
    check("lb_rdata", bus.rsp_rdata,    32'hFFFF_FF80);
    tick();
    issue(1'b0, 2'd0, 1'b1, 32'h103, 32'd0);
    tick();
    check("lbu_rdata", bus.rsp_rdata,   32'h0000_0080);
    tick();

    // Store half 0x202
    issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_ABCD);
    check("sh_amp", 32'(bus.mem_amp), 32'hC);
    check("sh_wd",  bus.mem_wd,       32'hABCD_ABCD);
    check("sh_a",   bus.mem_a,        32'h200);
    tick();
    check("sh_err", 32'(bus.rsp_err), 32'd0);
    tick();

    // Load half 0x102 signed, load word 0x100
    issue(1'b0, 2'd1, 1'b0, 32'h102, 32'd0);
    check("lh_amp",   32'(bus.mem_amp), 32'hC);
    tick();
    check("lh_rdata", bus.rsp_rdata,    32'hFFFF_8012);
    tick();
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    tick();
    check("lw_rdata", bus.rsp_rdata,    32'h8012_3456);
    tick();

    // Illegal size 11
    issue(1'b1, 2'd3, 1'b0, 32'h100, 32'h1234_5678);
    check("ill_we",     32'(bus.mem_we),    32'd0);
    check("ill_rvalid", 32'(bus.rsp_valid), 32'd1);
    check("ill_err",    32'(bus.rsp_err),   32'd1);
    check("ill_rdata",  bus.rsp_rdata,      32'd0);
    tick();
    check("ill_idle",   32'(bus.req_ready), 32'd1);

    // Misaligned load word 0x101
    rd_lo = 32'h3322_1100;
    issue(1'b0, 2'd2, 1'b0, 32'h101, 32'd0);
`ifdef MISALIGN_EN
    check("mis_a0",   bus.mem_a,        32'h100);
    check("mis_amp0", 32'(bus.mem_amp), 32'h2);
    tick();
    check("mis_a1",   bus.mem_a,        32'h100);
    check("mis_amp1", 32'(bus.mem_amp), 32'h4);
    tick();
    check("mis_a2",   bus.mem_a,        32'h100);
    check("mis_amp2", 32'(bus.mem_amp), 32'h8);
    tick();
    check("mis_a3",   bus.mem_a,        32'h104);
    check("mis_amp3", 32'(bus.mem_amp), 32'h1);
    check("mis_busy", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("mis_rvalid", 32'(bus.rsp_valid), 32'd1);
    check("mis_rdata",  bus.rsp_rdata,      32'h4433_2211);
    check("mis_err",    32'(bus.rsp_err),   32'd0);
`else
    check("mis_we",     32'(bus.mem_we),    32'd0);
    check("mis_rvalid", 32'(bus.rsp_valid), 32'd1);
    check("mis_err",    32'(bus.rsp_err),   32'd1);
    check("mis_rdata",  bus.rsp_rdata,      32'd0);
`endif
    tick();

    // Reset during ACCESS of a store
    issue(1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFE_F00D);
    check("rm_we_on", 32'(bus.mem_we), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("rm_we_off",  32'(bus.mem_we),    32'd0);
    check("rm_rvalid0", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("rm_rvalid1", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("rm_rvalid2", 32'(bus.rsp_valid), 32'd0);
    check("rm_ready",   32'(bus.req_ready), 32'd1);
    rd_lo = 32'h8012_3456;
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    tick();
    check("rm_next_rvalid", 32'(bus.rsp_valid), 32'd1);
    check("rm_next_rdata",  bus.rsp_rdata,      32'h8012_3456);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
